audio_frame_sequencer: RTL and testbench
========================================

// Module: audio_frame_sequencer
// PURPOSE
//  Host-side initiator for the AudioProcessor frame interface. Accepts 512b sample lines
//  from an upstream valid/ready stream and writes one frame (64 lines) into the processor.
//  Pulses start, waits for done, then reads the 64 processed lines back.
//  Emits them on a downstream valid/ready stream. Frames repeat while enable is high.
// PARAMETERS
//  LINE_W          512        width of one sample line (32 x 16b samples)
//  LINES_PER_FRAME 64         lines per processing frame
//  IDX_W           6          line index width, clog2(LINES_PER_FRAME)
//  DONE_TIMEOUT    1_000_000  max cycles in WAIT before abort
//  CNT_W           16         frame counter width
// PORTS
//  clk             in  1      system clock
//  rst_n           in  1      async active-low reset
//  enable          in  1      run frames; sampled only in IDLE
//  in_valid        in  1      upstream line valid
//  in_ready        out 1      upstream line ready
//  in_data         in  LINE_W upstream line
//  out_valid       out 1      processed line valid
//  out_ready       in  1      downstream ready
//  out_data        out LINE_W processed line
//  ap_data_wr_en   out 1      processor input write strobe
//  ap_input_index  out IDX_W  processor input line index
//  ap_data_in      out LINE_W processor input line
//  ap_start        out 1      processor start pulse
//  ap_done         in  1      processor done (level; rising edge = frame done)
//  ap_output_index out IDX_W  processor output line index
//  ap_data_out     in  LINE_W processor output line; comb. from ap_output_index
//  busy            out 1      high in any state but IDLE
//  frame_cnt       out CNT_W  completed frames, wraps
//  timeout_err     out 1      sticky; set on WAIT timeout; cleared only by rst_n
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, line idx 0, done_q 0. Reset mid-frame aborts; next frame restarts at idx 0.
//  All ap_* and out_* outputs are flops. in_ready = (state==LOAD), combinational.
//  IDLE: if enable -> LOAD, idx=0.
//  LOAD: on in_valid&in_ready, next cycle ap_data_wr_en=1, ap_input_index=idx, ap_data_in=in_data.
//   Strobe is 1 cycle per accepted line; idx++. After line LINES_PER_FRAME-1 -> START.
//  START: ap_start=1 for exactly 1 cycle; it is the cycle after the last ap_data_wr_en. -> WAIT, timer=0.
//  WAIT: done_rise = ap_done & ~done_q; done_q is always registered.
//   Rising edges outside WAIT are ignored. A level already high on entry is not done.
//   On done_rise -> FETCH, idx=0, ap_output_index=0.
//   Else timer++; at timer==DONE_TIMEOUT-1: timeout_err=1, -> IDLE, no output.
//  FETCH: 1 cycle; at its end capture ap_data_out into out_data, out_valid=1 -> PRESENT.
//  PRESENT: hold out_data/out_valid until out_ready.
//   On handshake: out_valid=0. If idx last: frame_cnt++ -> IDLE.
//   Else idx++, ap_output_index=idx+1 -> FETCH.
//   Min 2 cycles per output line.
//  enable low mid-frame does not abort; the frame completes, then IDLE holds.
//  Index arithmetic is IDX_W unsigned; no wrap occurs inside a frame. frame_cnt wraps at 2^CNT_W.
// STRUCTURE
//  Package audio_seq_pkg: seq_state_t enum {IDLE,LOAD,START,WAIT,FETCH,PRESENT};
//   LINE_W and LINES_PER_FRAME localparams shared with the AudioProcessor bench.
//  Sub-module audio_done_watchdog: rise detect + timeout counter; outputs done_rise and expired.
// TESTING
//  1 One frame: in_data[i]={32{i[15:0]}}; model sets done 100 cyc after start; ap_data_out=~line.
//    Expect 64 writes idx 0..63, one 1-cycle ap_start, 64 outputs ~in in order, frame_cnt=1.
//  2 Backpressure: in_valid 50% random, out_ready 1-of-3.
//    Order intact, no duplicate or dropped lines, ap_data_wr_en never back-to-back with the same idx.
//  3 Timeout: DONE_TIMEOUT=50, done never rises.
//    timeout_err=1 at cycle 50 of WAIT, busy=0, no out_valid; next frame still runs, err stays 1.
//  4 Done held high across frames: done falls 5 cyc after start, rises at cyc 80.
//    FETCH begins on the cycle after the rise, not at WAIT entry.
//  5 rst_n low after 30 LOAD lines: outputs 0 immediately.
//    Next frame writes start at idx 0; frame_cnt=0.
//  6 enable dropped during WAIT: frame finishes all 64 outputs, frame_cnt +1, stays IDLE, in_ready=0.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// Shared types and frame geometry for the audio frame sequencer and its bench.
package audio_seq_pkg;

    localparam int LINE_W          = 512;
    localparam int LINES_PER_FRAME = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        FETCH,
        PRESENT
    } seq_state_t;

endpackage

// File: rtl/audio_done_watchdog.sv
// Detects the rising edge of the processor done level and times out a stalled WAIT.
module audio_done_watchdog #(
    parameter int DONE_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ap_done,
    input  logic i_run,
    output logic o_done_rise,
    output logic o_expired
);

    localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DONE_TIMEOUT - 1);

    logic             r_done_q;
    logic [TMR_W-1:0] r_timer;

    // done_q follows ap_done in every state, so a level already high at WAIT entry is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done_q <= 1'b0;
        else        r_done_q <= i_ap_done;
    end

    // timer sits at 0 outside WAIT and counts WAIT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_timer <= '0;
        else if (!i_run) r_timer <= '0;
        else             r_timer <= r_timer + TMR_W'(1);
    end

    assign o_done_rise = i_ap_done & ~r_done_q;
    assign o_expired   = i_run && (r_timer == TMR_LAST);

endmodule

// File: rtl/audio_frame_sequencer.sv
// Host-side initiator: loads one frame into the AudioProcessor, starts it, waits for
// done, then streams the processed lines back out. Frames repeat while enable is high.
//
// state   | meaning
// IDLE    | waiting for enable
// LOAD    | accepting upstream lines, writing them into the processor
// START   | one-cycle ap_start pulse follows the last write
// WAIT    | waiting for a done rising edge or the timeout
// FETCH   | processor output line at ap_output_index is being read
// PRESENT | holding out_data until downstream accepts it
module audio_frame_sequencer
    import audio_seq_pkg::*;
#(
    parameter int LINE_W          = audio_seq_pkg::LINE_W,
    parameter int LINES_PER_FRAME = audio_seq_pkg::LINES_PER_FRAME,
    parameter int IDX_W           = 6,
    parameter int DONE_TIMEOUT    = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LINE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LINE_W-1:0] out_data,
    output logic              ap_data_wr_en,
    output logic [IDX_W-1:0]  ap_input_index,
    output logic [LINE_W-1:0] ap_data_in,
    output logic              ap_start,
    input  logic              ap_done,
    output logic [IDX_W-1:0]  ap_output_index,
    input  logic [LINE_W-1:0] ap_data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              timeout_err
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINES_PER_FRAME - 1);

    seq_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             w_done_rise;
    logic             w_expired;
    logic             w_in_wait;

    assign w_in_wait = (r_state == WAIT);
    assign in_ready  = (r_state == LOAD);
    assign busy      = (r_state != IDLE);

    audio_done_watchdog #(
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ap_done  (ap_done),
        .i_run      (w_in_wait),
        .o_done_rise(w_done_rise),
        .o_expired  (w_expired)
    );

    // frame sequencing FSM; every processor-side and downstream output is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_idx           <= '0;
            ap_data_wr_en   <= 1'b0;
            ap_input_index  <= '0;
            ap_data_in      <= '0;
            ap_start        <= 1'b0;
            ap_output_index <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            frame_cnt       <= '0;
            timeout_err     <= 1'b0;
        end else begin
            ap_data_wr_en <= 1'b0;
            ap_start      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= LOAD;
                        r_idx   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        ap_data_wr_en  <= 1'b1;
                        ap_input_index <= r_idx;
                        ap_data_in     <= in_data;
                        if (r_idx == IDX_LAST) r_state <= START;
                        else                   r_idx   <= r_idx + 1'b1;
                    end
                end
                START: begin
                    ap_start <= 1'b1;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    // a done edge in the expiring cycle still wins
                    if (w_done_rise) begin
                        r_state         <= FETCH;
                        r_idx           <= '0;
                        ap_output_index <= '0;
                    end else if (w_expired) begin
                        timeout_err <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                FETCH: begin
                    out_data  <= ap_data_out;
                    out_valid <= 1'b1;
                    r_state   <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r_idx == IDX_LAST) begin
                            frame_cnt <= frame_cnt + 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_idx           <= r_idx + 1'b1;
                            ap_output_index <= r_idx + 1'b1;
                            r_state         <= FETCH;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench for audio_frame_sequencer. Instance A uses the default timeout,
// instance B a 50-cycle timeout; sel picks which one is driven and observed.
module tb_audio_frame_sequencer;
    import audio_seq_pkg::*;

    localparam int IDX_W = 6;
    localparam int CNT_W = 16;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              enable    = 1'b0;
    logic              sel       = 1'b0;
    logic              in_valid  = 1'b0;
    logic [LINE_W-1:0] in_data   = '0;
    logic              out_ready = 1'b0;
    logic              ap_done   = 1'b0;
    logic [LINE_W-1:0] ap_data_out;

    logic en_a, en_b;
    assign en_a = enable & ~sel;
    assign en_b = enable & sel;

    logic              in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [LINE_W-1:0] out_data_a, out_data_b, ap_data_in_a, ap_data_in_b;
    logic              ap_data_wr_en_a, ap_data_wr_en_b, ap_start_a, ap_start_b;
    logic [IDX_W-1:0]  ap_input_index_a, ap_input_index_b, ap_output_index_a, ap_output_index_b;
    logic              busy_a, busy_b, timeout_err_a, timeout_err_b;
    logic [CNT_W-1:0]  frame_cnt_a, frame_cnt_b;

    logic              in_ready, out_valid, ap_data_wr_en, ap_start, busy, timeout_err;
    logic [LINE_W-1:0] out_data, ap_data_in;
    logic [IDX_W-1:0]  ap_input_index, ap_output_index;
    logic [CNT_W-1:0]  frame_cnt;

    assign in_ready        = sel ? in_ready_b        : in_ready_a;
    assign out_valid       = sel ? out_valid_b       : out_valid_a;
    assign out_data        = sel ? out_data_b        : out_data_a;
    assign ap_data_wr_en   = sel ? ap_data_wr_en_b   : ap_data_wr_en_a;
    assign ap_input_index  = sel ? ap_input_index_b  : ap_input_index_a;
    assign ap_data_in      = sel ? ap_data_in_b      : ap_data_in_a;
    assign ap_start        = sel ? ap_start_b        : ap_start_a;
    assign ap_output_index = sel ? ap_output_index_b : ap_output_index_a;
    assign busy            = sel ? busy_b            : busy_a;
    assign frame_cnt       = sel ? frame_cnt_b       : frame_cnt_a;
    assign timeout_err     = sel ? timeout_err_b     : timeout_err_a;

    audio_frame_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .ap_data_wr_en(ap_data_wr_en_a), .ap_input_index(ap_input_index_a), .ap_data_in(ap_data_in_a),
        .ap_start(ap_start_a), .ap_done(ap_done),
        .ap_output_index(ap_output_index_a), .ap_data_out(ap_data_out),
        .busy(busy_a), .frame_cnt(frame_cnt_a), .timeout_err(timeout_err_a)
    );

    audio_frame_sequencer #(.DONE_TIMEOUT(50)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .ap_data_wr_en(ap_data_wr_en_b), .ap_input_index(ap_input_index_b), .ap_data_in(ap_data_in_b),
        .ap_start(ap_start_b), .ap_done(ap_done),
        .ap_output_index(ap_output_index_b), .ap_data_out(ap_data_out),
        .busy(busy_b), .frame_cnt(frame_cnt_b), .timeout_err(timeout_err_b)
    );

    always #5 clk = ~clk;

    // processor model: line memory, output is the inverted stored line
    logic [LINE_W-1:0] mem [LINES_PER_FRAME];
    assign ap_data_out = ~mem[ap_output_index];

    logic [IDX_W-1:0]  wr_idx_log [1024];
    logic [LINE_W-1:0] wr_dat_log [1024];
    int   wr_n = 0, start_n = 0, ncyc = 0, last_wr_cyc = 0, start_cyc = 0;
    logic prev_wr = 1'b0, dup_wr = 1'b0;
    logic [IDX_W-1:0] prev_idx = '0;

    always @(negedge clk) begin
        ncyc     <= ncyc + 1;
        prev_wr  <= ap_data_wr_en;
        prev_idx <= ap_input_index;
        if (ap_data_wr_en === 1'b1) begin
            mem[ap_input_index] <= ap_data_in;
            if (wr_n < 1024) begin
                wr_idx_log[wr_n] <= ap_input_index;
                wr_dat_log[wr_n] <= ap_data_in;
            end
            wr_n        <= wr_n + 1;
            last_wr_cyc <= ncyc;
            if (prev_wr && prev_idx == ap_input_index) dup_wr <= 1'b1;
        end
        if (ap_start === 1'b1) begin
            start_n   <= start_n + 1;
            start_cyc <= ncyc;
        end
    end

    int step_cnt = 0;
    always @(posedge clk) step_cnt <= step_cnt + 1;

    int checks = 0;
    int errors = 0;
    int start_step, first_out_step, got_n;
    logic [LINE_W-1:0] got [LINES_PER_FRAME];

    function automatic logic [LINE_W-1:0] line_of(input int i, input logic [15:0] seed);
        logic [15:0] v;
        v = 16'(i) ^ seed;
        return {32{v}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_lines(input logic [15:0] seed, input bit rand_in, input int n, input bit drop);
        int i, g;
        bit acc;
        i = 0;
        g = 0;
        enable = 1'b1;
        while (i < n && g < 4000) begin
            in_valid = rand_in ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = line_of(i, seed);
            acc      = in_valid && in_ready;
            step();
            g++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        if (drop) enable = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL feed_lines accepted %0d required %0d", i, n);
        end
    endtask

    task automatic done_ctl(input int rise_at, input bit drop_en);
        int g, k;
        g = 0;
        while (ap_start !== 1'b1 && g < 5000) begin
            step();
            g++;
        end
        checks++;
        if (ap_start !== 1'b1) begin
            errors++;
            $display("FAIL start_wait ap_start %b required 1", ap_start);
        end else begin
            start_step = step_cnt;
            k = 0;
            while (k < rise_at) begin
                if (k == 5) ap_done = 1'b0;
                if (k == 10 && drop_en) enable = 1'b0;
                step();
                k++;
            end
            ap_done = 1'b1;
        end
    endtask

    task automatic collect(input int div, input int n);
        int g, ph;
        g = 0;
        ph = 0;
        got_n = 0;
        first_out_step = -1;
        while (got_n < n && g < 20000) begin
            out_ready = (div <= 1) ? 1'b1 : ((ph % div) == 0);
            ph++;
            if (out_valid === 1'b1 && first_out_step < 0) first_out_step = step_cnt;
            if (out_valid === 1'b1 && out_ready) begin
                got[got_n] = out_data;
                got_n++;
            end
            step();
            g++;
        end
        out_ready = 1'b0;
        checks++;
        if (got_n != n) begin
            errors++;
            $display("FAIL collect lines %0d required %0d", got_n, n);
        end
    endtask

    task automatic run_frame(input logic [15:0] seed, input bit rand_in, input int div,
                             input int rise_at, input bit drop_in_wait);
        fork
            feed_lines(seed, rand_in, LINES_PER_FRAME, !drop_in_wait);
            done_ctl(rise_at, drop_in_wait);
            collect(div, LINES_PER_FRAME);
        join
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({in_ready, busy, out_valid, ap_start, ap_data_wr_en, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 000000",
                     {in_ready, busy, out_valid, ap_start, ap_data_wr_en, timeout_err});
        end
        checks++;
        if (frame_cnt !== '0 || ap_input_index !== '0 || ap_output_index !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_values frame_cnt %0h in_idx %0h out_idx %0h required 0",
                     frame_cnt, ap_input_index, ap_output_index);
        end
        checks++;
        if (timeout_err_b !== 1'b0 || busy_b !== 1'b0 || frame_cnt_b !== '0) begin
            errors++;
            $display("FAIL reset_b err %b busy %b cnt %0d required 0", timeout_err_b, busy_b, frame_cnt_b);
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_enable busy %b in_ready %b required 0", busy, in_ready);
        end
    endtask

    task automatic test_one_frame();
        int base, sb;
        sel = 1'b0;
        base = wr_n;
        sb = start_n;
        run_frame(16'h0000, 1'b0, 1, 100, 1'b0);
        checks++;
        if (wr_n - base != LINES_PER_FRAME) begin
            errors++;
            $display("FAIL one_write_count got %0d required 64", wr_n - base);
        end
        for (int j = 0; j < LINES_PER_FRAME; j++) begin
            checks++;
            if (wr_idx_log[base+j] !== IDX_W'(j) || wr_dat_log[base+j] !== line_of(j, 16'h0000)) begin
                errors++;
                $display("FAIL one_write[%0d] idx %0d required %0d data %h", j, wr_idx_log[base+j], j, wr_dat_log[base+j]);
            end
        end
        checks++;
        if (start_n - sb != 1 || start_cyc != last_wr_cyc + 1) begin
            errors++;
            $display("FAIL one_start pulses %0d required 1, start at %0d required %0d",
                     start_n - sb, start_cyc, last_wr_cyc + 1);
        end
        checks++;
        if (first_out_step - start_step != 102) begin
            errors++;
            $display("FAIL one_latency got %0d required 102", first_out_step - start_step);
        end
        for (int j = 0; j < LINES_PER_FRAME; j++) begin
            checks++;
            if (got[j] !== ~line_of(j, 16'h0000)) begin
                errors++;
                $display("FAIL one_out[%0d] got %h required %h", j, got[j], ~line_of(j, 16'h0000));
            end
        end
        step();
        checks++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL one_end frame_cnt %0d busy %b out_valid %b required 1 0 0", frame_cnt, busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int base;
        sel = 1'b0;
        base = wr_n;
        run_frame(16'hBEEF, 1'b1, 3, 100, 1'b0);
        checks++;
        if (wr_n - base != LINES_PER_FRAME || dup_wr !== 1'b0) begin
            errors++;
            $display("FAIL bp_writes count %0d required 64 dup %b required 0", wr_n - base, dup_wr);
        end
        for (int j = 0; j < LINES_PER_FRAME; j++) begin
            checks++;
            if (wr_idx_log[base+j] !== IDX_W'(j) || got[j] !== ~line_of(j, 16'hBEEF)) begin
                errors++;
                $display("FAIL bp_line[%0d] idx %0d out %h required %h", j, wr_idx_log[base+j], got[j], ~line_of(j, 16'hBEEF));
            end
        end
        repeat (4) step();
        checks++;
        if (out_valid !== 1'b0 || frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bp_end out_valid %b frame_cnt %0d required 0 2", out_valid, frame_cnt);
        end
    endtask

    task automatic test_timeout();
        int g;
        bit saw_ov;
        sel = 1'b1;
        ap_done = 1'b0;
        saw_ov = 1'b0;
        fork
            feed_lines(16'h00A5, 1'b0, LINES_PER_FRAME, 1'b1);
            begin
                g = 0;
                while (ap_start !== 1'b1 && g < 5000) begin
                    step();
                    g++;
                end
                checks++;
                if (ap_start !== 1'b1) begin
                    errors++;
                    $display("FAIL to_start ap_start %b required 1", ap_start);
                end
                for (int j = 1; j < 50; j++) begin
                    step();
                    if (out_valid === 1'b1) saw_ov = 1'b1;
                end
                checks++;
                if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL to_cycle49 err %b busy %b required 0 1", timeout_err, busy);
                end
                step();
                checks++;
                if (timeout_err !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL to_cycle50 err %b busy %b required 1 0", timeout_err, busy);
                end
            end
        join
        repeat (5) begin
            step();
            if (out_valid === 1'b1 || busy === 1'b1) saw_ov = 1'b1;
        end
        checks++;
        if (saw_ov || frame_cnt !== '0) begin
            errors++;
            $display("FAIL to_quiet out activity %b frame_cnt %0d required 0 0", saw_ov, frame_cnt);
        end
        run_frame(16'h0F0F, 1'b0, 1, 20, 1'b0);
        checks++;
        if (first_out_step - start_step != 22) begin
            errors++;
            $display("FAIL to_next_latency got %0d required 22", first_out_step - start_step);
        end
        checks++;
        if (got[0] !== ~line_of(0, 16'h0F0F) || got[63] !== ~line_of(63, 16'h0F0F)) begin
            errors++;
            $display("FAIL to_next_data first %h last %h", got[0], got[63]);
        end
        step();
        checks++;
        if (timeout_err !== 1'b1 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL to_sticky err %b frame_cnt %0d required 1 1", timeout_err, frame_cnt);
        end
        sel = 1'b0;
    endtask

    task automatic test_done_held();
        sel = 1'b0;
        run_frame(16'h3C3C, 1'b0, 1, 80, 1'b0);
        checks++;
        if (first_out_step - start_step != 82) begin
            errors++;
            $display("FAIL held_latency got %0d required 82", first_out_step - start_step);
        end
        checks++;
        if (got[17] !== ~line_of(17, 16'h3C3C)) begin
            errors++;
            $display("FAIL held_data got %h required %h", got[17], ~line_of(17, 16'h3C3C));
        end
        step();
        checks++;
        if (frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL held_cnt got %0d required 3", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        sel = 1'b0;
        feed_lines(16'h1111, 1'b0, 30, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, out_valid, ap_start, ap_data_wr_en, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_flags got %b required 000000",
                     {in_ready, busy, out_valid, ap_start, ap_data_wr_en, timeout_err});
        end
        checks++;
        if (frame_cnt !== '0 || ap_input_index !== '0 || ap_data_in !== '0) begin
            errors++;
            $display("FAIL rstmid_values frame_cnt %0d in_idx %0d required 0", frame_cnt, ap_input_index);
        end
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        base = wr_n;
        run_frame(16'h2222, 1'b0, 1, 100, 1'b0);
        for (int j = 0; j < LINES_PER_FRAME; j++) begin
            checks++;
            if (wr_idx_log[base+j] !== IDX_W'(j) || got[j] !== ~line_of(j, 16'h2222)) begin
                errors++;
                $display("FAIL rstmid_line[%0d] idx %0d out %h required %h", j, wr_idx_log[base+j], got[j], ~line_of(j, 16'h2222));
            end
        end
        step();
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_cnt got %0d required 1", frame_cnt);
        end
    endtask

    task automatic test_enable_drop();
        int sb;
        bit bad;
        sel = 1'b0;
        sb = start_n;
        bad = 1'b0;
        run_frame(16'h4444, 1'b0, 2, 100, 1'b1);
        checks++;
        if (got[0] !== ~line_of(0, 16'h4444) || got[63] !== ~line_of(63, 16'h4444)) begin
            errors++;
            $display("FAIL endrop_data first %h last %h", got[0], got[63]);
        end
        repeat (20) begin
            step();
            if (busy !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || frame_cnt !== 16'd2 || start_n - sb != 1) begin
            errors++;
            $display("FAIL endrop_idle stray activity %b frame_cnt %0d required 2 starts %0d required 1",
                     bad, frame_cnt, start_n - sb);
        end
        checks++;
        if (dup_wr !== 1'b0) begin
            errors++;
            $display("FAIL dup_write flag %b required 0", dup_wr);
        end
    endtask

    initial begin
        test_reset();
        test_one_frame();
        test_backpressure();
        test_timeout();
        test_done_held();
        test_reset_mid_load();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
